uart_rx_ctrl: RTL and testbench
===============================

# uart_rx_ctrl

Receive-side controller for the 8N1 UART receiver core. It owns the core's receive enable and generates the core's per-bit sample strobe from a programmable divisor, so samples land at bit centres. It captures each completed byte into a 16-entry FIFO and presents that FIFO to the CPU's memory-mapped UART register block. It also reports FIFO level, a sticky overrun flag and a level interrupt.

## Interface
- DIV_W, 16, width of baud divisor (clock cycles per bit)
- DEFAULT_DIV, 868, divisor after reset (100 MHz / 115200)
- FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW
- IRQ_LEVEL, 1, O_irq asserts when level ≥ this value
- I_clk  in  1  system clock (100 MHz)
- I_rst  in  1  asynchronous, active-high reset
- I_enable  in  1  receive enable from control register
- I_div_we  in  1  divisor write strobe
- I_div  in  DIV_W  new divisor value
- I_flush  in  1  discard all FIFO contents
- O_rx_start  out  1  receive enable to core
- I_bps_clk_en  in  1  core's bit-clock request (high while a frame is in progress)
- O_bps_rx_clk  out  1  one-cycle sample strobe to core
- I_rx_done  in  1  core byte-complete pulse
- I_rx_data  in  8  core parallel byte, valid with I_rx_done
- I_rd_en  in  1  pop request from bus
- O_rd_data  out  8  FIFO head byte (first-word-fall-through)
- O_rx_valid  out  1  FIFO not empty
- O_level  out  FIFO_AW+1  entries held, 0..2**FIFO_AW
- O_overrun  out  1  sticky: a byte was dropped
- I_ovr_clr  in  1  clear O_overrun
- O_irq  out  1  level ≥ IRQ_LEVEL

## Operation
- Reset values:
  - O_rx_start 0, O_bps_rx_clk 0, O_rx_valid 0, O_level 0, O_overrun 0, O_irq 0, O_rd_data 8'h00.
  - Divisor register = DEFAULT_DIV; baud FSM in IDLE.
- O_rx_start is I_enable, registered.
  - Deasserting I_enable mid-frame does not abort the frame; the core completes it, and the resulting byte is still pushed.
- Divisor:
  - I_div_we loads a pending value; writes below 4 are clamped to 4.
  - The pending value becomes active only while the baud FSM is in IDLE. A mid-frame write takes effect at the next IDLE cycle and never alters the current frame.
- Baud FSM with states IDLE, HALF and FULL, and counter cnt (DIV_W bits):
  - IDLE: cnt=0. When I_bps_clk_en=1, go to HALF.
  - HALF: cnt increments. When cnt = (D>>1)-1, pulse O_bps_rx_clk, clear cnt, go to FULL.
  - FULL: cnt increments. When cnt = D-1, pulse O_bps_rx_clk and clear cnt.
  - Any state: I_bps_clk_en=0 forces IDLE and cnt=0 on the next cycle. No strobe is issued in that cycle.
- FIFO (depth 2**FIFO_AW, first-word-fall-through):
  - Push on I_rx_done; pop on I_rd_en & O_rx_valid.
  - I_rd_en while empty is ignored.
  - Full and push with no pop: the byte is dropped and O_overrun is set.
  - Full and push with pop in the same cycle: both happen; level is unchanged; no overrun.
  - Empty and push with I_rd_en in the same cycle: push only.
  - I_flush: level goes to 0 and pointers are reset. A push in the same cycle is discarded, without overrun.
  - Pointers wrap modulo depth; the full/empty decision uses the extra level bit.
- O_overrun: when set and I_ovr_clr occur in the same cycle, set wins.
- O_rd_data is 8'h00 whenever the FIFO is empty.

## Timing
- I_enable at cycle t → O_rx_start at t+1.
- I_bps_clk_en first high at cycle t:
  - First strobe at t+1+(D>>1).
  - Subsequent strobes every D cycles.
  - Strobe width is exactly 1 cycle.
- I_rx_done at t:
  - O_rx_valid, O_level and O_irq update at t+1.
  - O_rd_data shows the byte at t+1 if the FIFO was empty.
- Pop at t: O_rd_data shows the next entry and O_level decrements at t+1.
- Overrun drop at t → O_overrun=1 at t+1.
- I_rst asserted at any time, including mid-frame: all outputs immediately return to reset values and FIFO contents are lost.

## Structure
- Shared package uart_pkg:
  - UART_DATA_W = 8
  - UART_MIN_DIV = 4
  - UART_DEFAULT_DIV = 868
  - baud FSM state enum (IDLE, HALF, FULL), shared with the planned TX controller.
- Sub-module uart_rx_fifo:
  - Synchronous FWFT FIFO, parameterised by width and address width.
  - Ports: push, pop, flush, din, dout, level, full, empty.
  - Reused later by TX.
- Baud FSM, divisor register, overrun logic and IRQ compare live inline in uart_rx_ctrl.

## Test plan
- Reset then I_enable=1, D=868:
  - Hold I_bps_clk_en high; the first strobe is 435 cycles after it rises, then one every 868 cycles.
  - Drop I_bps_clk_en; no further strobes.
- Write I_div=2 → active divisor 4. Write I_div=100 mid-frame → strobes stay at the old period until I_bps_clk_en falls; the next frame uses 100.
- Push 0x55, 0xA3, 0x0F → O_level=3 and O_rd_data=0x55. Three pops return 0x55, 0xA3, 0x0F in order, then O_rx_valid=0 and O_rd_data=0x00.
- Fill 16 bytes, then push 0x77 → dropped, O_overrun=1, O_level=16.
  - Repeat with a simultaneous pop → 0x77 accepted at the tail, no overrun.
  - I_ovr_clr together with a new overrun → O_overrun stays 1.
- Empty FIFO with simultaneous push and rd_en → level 1. I_flush with simultaneous push → level 0, O_overrun unchanged.
- Assert I_rst mid-frame with O_level=5 → all outputs at reset values and baud FSM in IDLE; the next frame is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions for the RX controller and the planned TX controller.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package uart_pkg;

  // Width of one UART character.
  localparam int UART_DATA_W = 8;

  // Smallest usable divisor: the half-bit phase needs at least two cycles.
  localparam int UART_MIN_DIV = 4;

  // Divisor after reset: 100 MHz core clock / 115200 baud.
  localparam int UART_DEFAULT_DIV = 868;

  // Baud generator phases: waiting, half-bit to the first bit centre, then full bits.
  typedef enum logic [1:0] {
    BAUD_IDLE = 2'd0,
    BAUD_HALF = 2'd1,
    BAUD_FULL = 2'd2
  } baud_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word-fall-through FIFO, depth 2**AW, used between the UART core and the bus.
// Latency: a push is visible on dout_o/level_o the next cycle; dout_o always shows the head entry.
// Backpressure: push while full is refused unless a pop happens in the same cycle; flush beats push and pop.
module uart_rx_fifo #(
  parameter int W  = 8,
  parameter int AW = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  logic [W-1:0]  din_i,
  output logic [W-1:0]  dout_o,
  output logic [AW:0]   level_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          do_push;
  logic          do_pop;

  // The extra level bit is set only at exactly DEPTH entries, so it is the full flag.
  assign full_o  = level_q[AW];
  assign empty_o = (level_q == '0);
  assign level_o = level_q;

  // A pop on an empty FIFO is ignored; a full FIFO accepts a push only when it is popped too.
  assign do_pop  = pop_i & ~empty_o & ~flush_i;
  assign do_push = push_i & (~full_o | do_pop) & ~flush_i;

  // Head entry falls through; an empty FIFO reads as zero rather than stale storage.
  assign dout_o = empty_o ? '0 : mem_q[rd_ptr_q];

  // Pointer and level next-state; flush restarts everything from slot zero.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   level_d = level_q + (AW+1)'(1);
        2'b01:   level_d = level_q - (AW+1)'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // Pointer and level state; contents are abandoned on reset simply by zeroing the level.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage write; when full with a simultaneous pop this overwrites the slot being vacated.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive-side controller for the 8N1 UART core: rx enable, bit-centre sample strobe, byte FIFO for the CPU.
// Latency: O_rx_start and FIFO outputs follow their inputs by one cycle; first strobe lands 1+(D>>1) cycles after frame start.
// Backpressure: none toward the core; a byte arriving at a full FIFO without a pop is dropped and O_overrun is set.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = UART_DEFAULT_DIV,
  parameter int FIFO_AW     = 4,
  parameter int IRQ_LEVEL   = 1
) (
  input  logic                   I_clk,
  input  logic                   I_rst,
  input  logic                   I_enable,
  input  logic                   I_div_we,
  input  logic [DIV_W-1:0]       I_div,
  input  logic                   I_flush,
  output logic                   O_rx_start,
  input  logic                   I_bps_clk_en,
  output logic                   O_bps_rx_clk,
  input  logic                   I_rx_done,
  input  logic [UART_DATA_W-1:0] I_rx_data,
  input  logic                   I_rd_en,
  output logic [UART_DATA_W-1:0] O_rd_data,
  output logic                   O_rx_valid,
  output logic [FIFO_AW:0]       O_level,
  output logic                   O_overrun,
  input  logic                   I_ovr_clr,
  output logic                   O_irq
);

  localparam logic [DIV_W-1:0]   MIN_DIV_C = DIV_W'(UART_MIN_DIV);
  localparam logic [DIV_W-1:0]   RST_DIV_C = DIV_W'(DEFAULT_DIV);
  localparam logic [FIFO_AW:0]   IRQ_LVL_C = (FIFO_AW+1)'(IRQ_LEVEL);

  // Control registers.
  logic                   rx_start_q;
  logic [DIV_W-1:0]       div_pend_q, div_pend_d;
  logic [DIV_W-1:0]       div_act_q,  div_act_d;

  // Baud generator.
  baud_state_e            state_q, state_d;
  logic [DIV_W-1:0]       cnt_q, cnt_d;
  logic                   strobe_q, strobe_d;
  logic [DIV_W-1:0]       half_last;
  logic [DIV_W-1:0]       full_last;
  logic                   half_hit;
  logic                   full_hit;

  // FIFO and status.
  logic                   fifo_pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [FIFO_AW:0]       fifo_level;
  logic [UART_DATA_W-1:0] fifo_dout;
  logic                   drop;
  logic                   ovr_q, ovr_d;

  // ---------------------------------------------------------------------------
  // Divisor: writes land in a pending register and are adopted only between frames,
  // so a frame in progress always keeps the bit period it started with.
  // ---------------------------------------------------------------------------

  // Clamp new divisor writes and adopt the pending value whenever the generator is idle.
  always_comb begin
    div_pend_d = div_pend_q;
    if (I_div_we) begin
      div_pend_d = (I_div < MIN_DIV_C) ? MIN_DIV_C : I_div;
    end
    div_act_d = (state_q == BAUD_IDLE) ? div_pend_q : div_act_q;
  end

  // Enable pipeline register and both divisor registers.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      rx_start_q <= 1'b0;
      div_pend_q <= RST_DIV_C;
      div_act_q  <= RST_DIV_C;
    end else begin
      rx_start_q <= I_enable;
      div_pend_q <= div_pend_d;
      div_act_q  <= div_act_d;
    end
  end

  assign O_rx_start = rx_start_q;

  // ---------------------------------------------------------------------------
  // Baud FSM: half a bit to reach the start-bit centre, then whole bits.
  // The strobe is registered, which supplies the extra cycle before the first centre.
  // ---------------------------------------------------------------------------

  assign half_last = (div_act_q >> 1) - DIV_W'(1);
  assign full_last = div_act_q - DIV_W'(1);
  assign half_hit  = (cnt_q == half_last);
  assign full_hit  = (cnt_q == full_last);

  // Baud state, counter and strobe registers.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      state_q  <= BAUD_IDLE;
      cnt_q    <= '0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      strobe_q <= strobe_d;
    end
  end

  // Phase sequencing; losing the core's bit-clock request always returns to idle.
  always_comb begin
    state_d = state_q;
    if (!I_bps_clk_en) begin
      state_d = BAUD_IDLE;
    end else begin
      unique case (state_q)
        BAUD_IDLE: state_d = BAUD_HALF;
        BAUD_HALF: state_d = half_hit ? BAUD_FULL : BAUD_HALF;
        BAUD_FULL: state_d = BAUD_FULL;
        default:   state_d = BAUD_IDLE;
      endcase
    end
  end

  // Counter and strobe for each phase; no strobe is issued in a cycle where the request drops.
  always_comb begin
    cnt_d    = '0;
    strobe_d = 1'b0;
    if (I_bps_clk_en) begin
      unique case (state_q)
        BAUD_HALF: begin
          if (half_hit) begin
            strobe_d = 1'b1;
          end else begin
            cnt_d = cnt_q + DIV_W'(1);
          end
        end
        BAUD_FULL: begin
          if (full_hit) begin
            strobe_d = 1'b1;
          end else begin
            cnt_d = cnt_q + DIV_W'(1);
          end
        end
        default: begin
          cnt_d    = '0;
          strobe_d = 1'b0;
        end
      endcase
    end
  end

  assign O_bps_rx_clk = strobe_q;

  // ---------------------------------------------------------------------------
  // Byte FIFO toward the CPU, plus overrun and interrupt status.
  // ---------------------------------------------------------------------------

  assign fifo_pop = I_rd_en & ~fifo_empty;

  uart_rx_fifo #(
    .W  (UART_DATA_W),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk_i   (I_clk),
    .rst_i   (I_rst),
    .push_i  (I_rx_done),
    .pop_i   (fifo_pop),
    .flush_i (I_flush),
    .din_i   (I_rx_data),
    .dout_o  (fifo_dout),
    .level_o (fifo_level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // A byte is lost only when the FIFO is full, nobody pops, and no flush is discarding it anyway.
  assign drop = I_rx_done & fifo_full & ~fifo_pop & ~I_flush;

  // Sticky overrun; a new drop outranks a clear in the same cycle.
  always_comb begin
    ovr_d = drop | (ovr_q & ~I_ovr_clr);
  end

  // Overrun flag register.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      ovr_q <= 1'b0;
    end else begin
      ovr_q <= ovr_d;
    end
  end

  assign O_overrun  = ovr_q;
  assign O_rd_data  = fifo_dout;
  assign O_rx_valid = ~fifo_empty;
  assign O_level    = fifo_level;
  assign O_irq      = (fifo_level >= IRQ_LVL_C);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed vectors, strobe-timing sequences and randomized traffic.
// Latency: outputs are compared 1 time unit after every rising clock edge.
// Backpressure: not applicable; the bench drives the core and bus sides directly.
module tb_uart_rx_ctrl;

  localparam int DIV_W   = 16;
  localparam int FIFO_AW = 4;
  localparam int DEPTH   = 16;

  logic              I_clk;
  logic              I_rst;
  logic              I_enable;
  logic              I_div_we;
  logic [DIV_W-1:0]  I_div;
  logic              I_flush;
  logic              O_rx_start;
  logic              I_bps_clk_en;
  logic              O_bps_rx_clk;
  logic              I_rx_done;
  logic [7:0]        I_rx_data;
  logic              I_rd_en;
  logic [7:0]        O_rd_data;
  logic              O_rx_valid;
  logic [FIFO_AW:0]  O_level;
  logic              O_overrun;
  logic              I_ovr_clr;
  logic              O_irq;

  uart_rx_ctrl #(
    .DIV_W       (DIV_W),
    .DEFAULT_DIV (868),
    .FIFO_AW     (FIFO_AW),
    .IRQ_LEVEL   (1)
  ) dut (
    .I_clk        (I_clk),
    .I_rst        (I_rst),
    .I_enable     (I_enable),
    .I_div_we     (I_div_we),
    .I_div        (I_div),
    .I_flush      (I_flush),
    .O_rx_start   (O_rx_start),
    .I_bps_clk_en (I_bps_clk_en),
    .O_bps_rx_clk (O_bps_rx_clk),
    .I_rx_done    (I_rx_done),
    .I_rx_data    (I_rx_data),
    .I_rd_en      (I_rd_en),
    .O_rd_data    (O_rd_data),
    .O_rx_valid   (O_rx_valid),
    .O_level      (O_level),
    .O_overrun    (O_overrun),
    .I_ovr_clr    (I_ovr_clr),
    .O_irq        (O_irq)
  );

  initial I_clk = 1'b0;
  always #5 I_clk = ~I_clk;

  // Bookkeeping.
  int     vec_cnt  = 0;
  int     miss_cnt = 0;
  longint cyc      = 0;

  // Reference model: byte queue, sticky flag and frame-level strobe arithmetic.
  logic [7:0] m_q[$];
  bit         m_ovr;
  bit         m_start;
  bit         m_strobe;
  int         m_pend;
  bit         run_act;
  longint     run_s;
  int         run_d;

  typedef struct {
    logic       done;
    logic [7:0] data;
    logic       rd;
    logic       flush;
    int         exp_level;
    logic [7:0] exp_data;
    logic       exp_valid;
  } vec_t;

  vec_t tbl[11];

  task automatic check(input string name, input longint act, input longint exp);
    vec_cnt++;
    if (act != exp) begin
      miss_cnt++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ovr    = 1'b0;
    m_start  = 1'b0;
    m_strobe = 1'b0;
    m_pend   = 868;
    run_act  = 1'b0;
    run_s    = 0;
    run_d    = 868;
  endtask

  task automatic check_outputs();
    check("rx_start", O_rx_start,   m_start);
    check("strobe",   O_bps_rx_clk, m_strobe);
    check("rx_valid", O_rx_valid,   m_q.size() > 0);
    check("level",    O_level,      m_q.size());
    check("rd_data",  O_rd_data,    (m_q.size() > 0) ? m_q[0] : 8'h00);
    check("overrun",  O_overrun,    m_ovr);
    check("irq",      O_irq,        m_q.size() >= 1);
  endtask

  // One clock: advance the model with this cycle's inputs, then compare after the edge.
  task automatic tick();
    bit     drop;
    bit     pop;
    longint k;
    @(posedge I_clk);
    if (I_rst) begin
      model_reset();
    end else begin
      m_start = I_enable;
      if (I_bps_clk_en) begin
        if (!run_act) begin
          run_act = 1'b1;
          run_s   = cyc;
          run_d   = m_pend;
        end
        k        = cyc - run_s - longint'(run_d / 2);
        m_strobe = (k >= 0) && ((k % run_d) == 0);
      end else begin
        run_act  = 1'b0;
        m_strobe = 1'b0;
      end
      if (I_div_we) m_pend = (int'(I_div) < 4) ? 4 : int'(I_div);

      drop = 1'b0;
      if (I_flush) begin
        m_q.delete();
      end else begin
        pop = I_rd_en && (m_q.size() > 0);
        if (pop) void'(m_q.pop_front());
        if (I_rx_done) begin
          if (m_q.size() == DEPTH) drop = 1'b1;
          else m_q.push_back(I_rx_data);
        end
      end
      m_ovr = drop || (m_ovr && !I_ovr_clr);
    end
    cyc++;
    #1;
    check_outputs();
  endtask

  task automatic clear_pulses();
    I_div_we  = 1'b0;
    I_flush   = 1'b0;
    I_rx_done = 1'b0;
    I_rd_en   = 1'b0;
    I_ovr_clr = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] b, input logic rd);
    I_rx_done = 1'b1;
    I_rx_data = b;
    I_rd_en   = rd;
    tick();
    clear_pulses();
  endtask

  // Run n cycles, noting the first strobe offset from rise, the first gap and the strobe count.
  task automatic run_collect(input int n, input longint rise,
                             output longint first, output longint gap, output int count);
    longint prev;
    first = -1;
    gap   = -1;
    count = 0;
    prev  = -1;
    for (int i = 0; i < n; i++) begin
      tick();
      if (O_bps_rx_clk) begin
        if (count == 0) first = cyc - rise;
        else if (count == 1) gap = cyc - prev;
        prev = cyc;
        count++;
      end
    end
  endtask

  initial begin
    longint rise;
    longint first;
    longint gap;
    int     count;

    I_rst        = 1'b1;
    I_enable     = 1'b0;
    I_bps_clk_en = 1'b0;
    I_div        = '0;
    I_rx_data    = '0;
    clear_pulses();
    model_reset();

    tbl[0]  = '{1'b1, 8'h55, 1'b0, 1'b0, 1, 8'h55, 1'b1};
    tbl[1]  = '{1'b1, 8'hA3, 1'b0, 1'b0, 2, 8'h55, 1'b1};
    tbl[2]  = '{1'b1, 8'h0F, 1'b0, 1'b0, 3, 8'h55, 1'b1};
    tbl[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 2, 8'hA3, 1'b1};
    tbl[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 8'h0F, 1'b1};
    tbl[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 8'h00, 1'b0};
    tbl[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 8'h00, 1'b0};
    tbl[7]  = '{1'b1, 8'h11, 1'b1, 1'b0, 1, 8'h11, 1'b1};
    tbl[8]  = '{1'b1, 8'h22, 1'b0, 1'b1, 0, 8'h00, 1'b0};
    tbl[9]  = '{1'b1, 8'h33, 1'b0, 1'b0, 1, 8'h33, 1'b1};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 8'h00, 1'b0};

    // Reset state.
    #1;
    check("rst_level",  O_level,      0);
    check("rst_valid",  O_rx_valid,   0);
    check("rst_strobe", O_bps_rx_clk, 0);
    check("rst_rddata", O_rd_data,    0);
    tick();
    tick();
    I_rst = 1'b0;
    tick();

    // Enable is registered.
    I_enable = 1'b1;
    tick();
    check("rx_start_on", O_rx_start, 1);

    // Default divisor 868: first centre 435 cycles after the request rises, then every 868.
    I_bps_clk_en = 1'b1;
    rise = cyc;
    run_collect(2176, rise, first, gap, count);
    check("d868_first", first, 435);
    check("d868_gap",   gap,   868);
    check("d868_count", count, 3);
    I_bps_clk_en = 1'b0;
    run_collect(1000, cyc, first, gap, count);
    check("d868_quiet", count, 0);

    // Divisor write of 2 clamps to 4.
    I_div_we = 1'b1;
    I_div    = 16'd2;
    tick();
    clear_pulses();
    tick();
    I_bps_clk_en = 1'b1;
    rise = cyc;
    run_collect(20, rise, first, gap, count);
    check("d4_first", first, 3);
    check("d4_gap",   gap,   4);
    check("d4_count", count, 5);
    // Mid-frame write of 100 leaves the current frame at period 4.
    I_div_we = 1'b1;
    I_div    = 16'd100;
    tick();
    clear_pulses();
    run_collect(19, rise, first, gap, count);
    check("d4_mid_first", first, 23);
    check("d4_mid_gap",   gap,   4);
    check("d4_mid_count", count, 5);
    I_bps_clk_en = 1'b0;
    tick();
    tick();
    // Next frame picks up 100.
    I_bps_clk_en = 1'b1;
    rise = cyc;
    run_collect(260, rise, first, gap, count);
    check("d100_first", first, 51);
    check("d100_gap",   gap,   100);
    check("d100_count", count, 3);
    I_bps_clk_en = 1'b0;
    run_collect(300, cyc, first, gap, count);
    check("d100_quiet", count, 0);

    // Directed FIFO vectors.
    for (int i = 0; i < 11; i++) begin
      I_rx_done = tbl[i].done;
      I_rx_data = tbl[i].data;
      I_rd_en   = tbl[i].rd;
      I_flush   = tbl[i].flush;
      tick();
      clear_pulses();
      check("tbl_level", O_level,    tbl[i].exp_level);
      check("tbl_data",  O_rd_data,  tbl[i].exp_data);
      check("tbl_valid", O_rx_valid, tbl[i].exp_valid);
    end

    // Fill to 16, then overflow without a pop.
    for (int i = 0; i < DEPTH; i++) push_byte(8'(i * 7 + 1), 1'b0);
    check("full_level", O_level, 16);
    push_byte(8'h77, 1'b0);
    check("ovf_flag",  O_overrun, 1);
    check("ovf_level", O_level,   16);
    check("ovf_head",  O_rd_data, 8'h01);
    I_ovr_clr = 1'b1;
    tick();
    clear_pulses();
    check("ovr_cleared", O_overrun, 0);
    // Full with simultaneous pop: 0x77 accepted at the tail.
    push_byte(8'h77, 1'b1);
    check("fullpop_level", O_level,   16);
    check("fullpop_ovr",   O_overrun, 0);
    check("fullpop_head",  O_rd_data, 8'h08);
    for (int i = 0; i < DEPTH - 1; i++) begin
      I_rd_en = 1'b1;
      tick();
      clear_pulses();
    end
    check("tail_byte", O_rd_data, 8'h77);
    I_rd_en = 1'b1;
    tick();
    clear_pulses();
    check("drained", O_rx_valid, 0);

    // Clear and new overrun in the same cycle: set wins.
    for (int i = 0; i < DEPTH; i++) push_byte(8'(8'hC0 + i), 1'b0);
    I_ovr_clr = 1'b1;
    push_byte(8'h88, 1'b0);
    check("clr_vs_set", O_overrun, 1);
    // Flush with a simultaneous push: empty, overrun untouched.
    I_flush = 1'b1;
    push_byte(8'h99, 1'b0);
    check("flush_level", O_level,   0);
    check("flush_ovr",   O_overrun, 1);
    I_ovr_clr = 1'b1;
    tick();
    clear_pulses();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      I_enable  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 49) == 0) I_bps_clk_en = ~I_bps_clk_en;
      I_rx_done = ($urandom_range(0, 2) == 0);
      I_rx_data = 8'($urandom_range(0, 255));
      I_rd_en   = ($urandom_range(0, 2) == 0);
      I_flush   = ($urandom_range(0, 99) == 0);
      I_ovr_clr = ($urandom_range(0, 19) == 0);
      I_div_we  = ($urandom_range(0, 199) == 0);
      I_div     = 16'($urandom_range(0, 40));
      tick();
    end
    clear_pulses();
    I_bps_clk_en = 1'b0;
    I_enable     = 1'b1;
    I_flush      = 1'b1;
    I_ovr_clr    = 1'b1;
    tick();
    clear_pulses();

    // Reset mid-frame with five bytes held.
    for (int i = 0; i < 5; i++) push_byte(8'(8'h40 + i), 1'b0);
    check("pre_rst_level", O_level, 5);
    I_bps_clk_en = 1'b1;
    for (int i = 0; i < 30; i++) tick();
    #3;
    I_rst = 1'b1;
    #1;
    check("arst_start",  O_rx_start,   0);
    check("arst_strobe", O_bps_rx_clk, 0);
    check("arst_valid",  O_rx_valid,   0);
    check("arst_level",  O_level,      0);
    check("arst_ovr",    O_overrun,    0);
    check("arst_irq",    O_irq,        0);
    check("arst_data",   O_rd_data,    0);
    I_bps_clk_en = 1'b0;
    tick();
    I_rst = 1'b0;
    tick();
    I_bps_clk_en = 1'b1;
    rise = cyc;
    run_collect(440, rise, first, gap, count);
    check("post_rst_first", first, 435);
    check("post_rst_count", count, 1);
    push_byte(8'h5A, 1'b0);
    check("post_rst_level", O_level,   1);
    check("post_rst_data",  O_rd_data, 8'h5A);
    I_bps_clk_en = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
